// File: rtl/alu_result_tx_ctrl_pkg.sv
// Shared definitions for the ALU result transmit controller: parameter
// defaults and the byte-sequencing FSM state encoding.
package alu_result_tx_ctrl_pkg;

    localparam int unsigned WIDTH_DATA_DEFAULT = 8;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE,
        SEND_LO,
        ACK_LO,
        DONE_LO,
        SEND_HI,
        ACK_HI,
        DONE_HI
    } tx_state_t;

endpackage

// File: rtl/alu_result_tx_ctrl_result_fifo.sv
// Synchronous result buffer with full/empty flags; a push is accepted when
// full if a pop happens on the same edge.
module result_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_result_tx_ctrl.sv
// Buffers double-width ALU results and hands them to a byte-wide UART
// transmitter, low byte first, pacing each byte on the TX_BUSY handshake.
module alu_result_tx_ctrl
    import alu_result_tx_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = WIDTH_DATA_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*WIDTH_DATA-1:0] ALU_OUT,
    input  logic                    OUT_VALID,
    input  logic                    TX_BUSY,
    output logic [WIDTH_DATA-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    BUSY,
    output logic                    OVERFLOW
);

    tx_state_t                 state, state_nxt;
    logic [WIDTH_DATA-1:0]     tx_data, tx_data_nxt;
    logic [2*WIDTH_DATA-1:0]   head;
    logic                      full;
    logic                      empty;
    logic                      pop;
    logic                      ovf;

    result_fifo #(
        .WIDTH (2 * WIDTH_DATA),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (OUT_VALID),
        .push_data (ALU_OUT),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // The output byte is loaded on entry to a SEND state so it is registered
    // and holds its value for the rest of the transfer.
    always_comb begin
        state_nxt   = state;
        tx_data_nxt = tx_data;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !TX_BUSY) begin
                    state_nxt   = SEND_LO;
                    tx_data_nxt = head[WIDTH_DATA-1:0];
                end
            end
            SEND_LO: state_nxt = ACK_LO;
            ACK_LO:  if (TX_BUSY) state_nxt = DONE_LO;
            DONE_LO: begin
                if (!TX_BUSY) begin
                    state_nxt   = SEND_HI;
                    tx_data_nxt = head[2*WIDTH_DATA-1:WIDTH_DATA];
                end
            end
            SEND_HI: state_nxt = ACK_HI;
            ACK_HI:  if (TX_BUSY) state_nxt = DONE_HI;
            DONE_HI: begin
                if (!TX_BUSY) begin
                    state_nxt = IDLE;
                    pop       = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            tx_data <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx_data <= tx_data_nxt;
            if (OUT_VALID && full && !pop) ovf <= 1'b1;
        end
    end

    assign TX_P_DATA = tx_data;
    assign TX_D_VLD  = (state == SEND_LO) || (state == SEND_HI);
    assign BUSY      = !empty || (state != IDLE);
    assign OVERFLOW  = ovf;

endmodule

// File: tb/tb_alu_result_tx_ctrl.sv
// Self-checking bench: transaction-level reference model plus directed
// scenarios and randomized traffic against a simple UART busy model.
module tb_alu_result_tx_ctrl;

    localparam int W = 8;
    localparam int D = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [2*W-1:0]   ALU_OUT;
    logic             OUT_VALID;
    logic             TX_BUSY;
    logic [W-1:0]     TX_P_DATA;
    logic             TX_D_VLD;
    logic             BUSY;
    logic             OVERFLOW;

    always #5 clk = ~clk;

    alu_result_tx_ctrl #(
        .WIDTH_DATA (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ALU_OUT   (ALU_OUT),
        .OUT_VALID (OUT_VALID),
        .TX_BUSY   (TX_BUSY),
        .TX_P_DATA (TX_P_DATA),
        .TX_D_VLD  (TX_D_VLD),
        .BUSY      (BUSY),
        .OVERFLOW  (OVERFLOW)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a queue of buffered results, and the transfer in
    // progress described as (which byte, which handshake step).
    localparam int S_STROBE = 0;
    localparam int S_RISE   = 1;
    localparam int S_FALL   = 2;

    logic [2*W-1:0] mq[$];
    logic [W-1:0]   exp_bytes[$];
    bit             m_valid  = 0;
    bit             m_active = 0;
    int             m_byte   = 0;
    int             m_step   = 0;
    bit             m_ovf    = 0;
    logic [W-1:0]   m_txd    = '0;

    logic [W-1:0]   log_b[$];
    int             log_c[$];

    always @(posedge clk) begin
        bit             pop_now;
        bit             acc;
        logic [2*W-1:0] hd;
        cyc++;
        if (rst === 1'b0) begin
            mq.delete();
            exp_bytes.delete();
            m_active = 0;
            m_byte   = 0;
            m_step   = S_STROBE;
            m_ovf    = 0;
            m_txd    = '0;
            m_valid  = 1;
        end else if (m_valid) begin
            pop_now = m_active && m_byte == 1 && m_step == S_FALL && !TX_BUSY;
            acc     = OUT_VALID && (mq.size() < D || pop_now);
            if (OUT_VALID && !acc) m_ovf = 1;
            if (!m_active) begin
                if (mq.size() > 0 && !TX_BUSY) begin
                    m_active = 1;
                    m_byte   = 0;
                    m_step   = S_STROBE;
                    hd       = mq[0];
                    m_txd    = hd[W-1:0];
                end
            end else begin
                case (m_step)
                    S_STROBE: m_step = S_RISE;
                    S_RISE:   if (TX_BUSY) m_step = S_FALL;
                    default: begin
                        if (!TX_BUSY) begin
                            if (m_byte == 0) begin
                                m_byte = 1;
                                m_step = S_STROBE;
                                hd     = mq[0];
                                m_txd  = hd[2*W-1:W];
                            end else begin
                                m_active = 0;
                                void'(mq.pop_front());
                            end
                        end
                    end
                endcase
            end
            if (acc) begin
                mq.push_back(ALU_OUT);
                exp_bytes.push_back(ALU_OUT[W-1:0]);
                exp_bytes.push_back(ALU_OUT[2*W-1:W]);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("tx_d_vld", 32'(TX_D_VLD), 32'(m_active && m_step == S_STROBE));
            chk("tx_p_data", 32'(TX_P_DATA), 32'(m_txd));
            chk("busy", 32'(BUSY), 32'(m_active || mq.size() > 0));
            chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
            if (TX_D_VLD === 1'b1) begin
                log_b.push_back(TX_P_DATA);
                log_c.push_back(cyc);
                if (exp_bytes.size() == 0) chk("byte_order_extra", 32'(TX_P_DATA), 32'hFFFF_FFFF);
                else chk("byte_order", 32'(TX_P_DATA), 32'(exp_bytes.pop_front()));
            end
        end
    end

    // UART model: TX_BUSY rises the cycle after a strobe, for frame_len cycles.
    int unsigned frame_len   = 10;
    bit          rand_frames = 0;
    bit          hold        = 0;
    int unsigned uart_cnt    = 0;
    bit          last_vld    = 0;

    task automatic uart_update();
        if (last_vld) uart_cnt = rand_frames ? $urandom_range(12, 1) : frame_len;
        TX_BUSY = hold || (uart_cnt > 0);
        if (uart_cnt > 0) uart_cnt--;
        last_vld = (TX_D_VLD === 1'b1);
    endtask

    task automatic step(input bit ov, input logic [2*W-1:0] d, input bit r);
        @(posedge clk);
        #1;
        uart_update();
        rst       = r;
        OUT_VALID = ov;
        ALU_OUT   = d;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            step(1'b0, '0, 1'b1);
            if (BUSY === 1'b0 && uart_cnt == 0 && TX_BUSY === 1'b0) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", max_cyc);
        end
    endtask

    task automatic clear_log();
        log_b.delete();
        log_c.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  pc;
        bit  hit;
        logic [W-1:0] b2b [4];

        rst = 1'b0; OUT_VALID = 1'b0; ALU_OUT = '0; TX_BUSY = 1'b0;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("reset_tx_d_vld", 32'(TX_D_VLD), 32'd0);
        chk("reset_tx_p_data", 32'(TX_P_DATA), 32'd0);
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_overflow", 32'(OVERFLOW), 32'd0);

        // Single result with a 10-cycle frame
        clear_log();
        step(1'b1, 16'hA55A, 1'b1);
        pc = cyc;
        wait_idle(100);
        chk("single_count", 32'(log_b.size()), 32'd2);
        chk("single_lo", 32'(log_b[0]), 32'h5A);
        chk("single_lo_latency", 32'(log_c[0] - pc), 32'd2);
        chk("single_hi", 32'(log_b[1]), 32'hA5);
        chk("single_hi_cycle", 32'(log_c[1] - pc), 32'd14);
        chk("single_busy_end", 32'(BUSY), 32'd0);

        // Back-to-back results
        frame_len = 3;
        clear_log();
        step(1'b1, 16'h0102, 1'b1);
        step(1'b1, 16'h0304, 1'b1);
        wait_idle(100);
        b2b[0] = 8'h02; b2b[1] = 8'h01; b2b[2] = 8'h04; b2b[3] = 8'h03;
        chk("b2b_count", 32'(log_b.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("b2b_byte", 32'(log_b[i]), 32'(b2b[i]));
        chk("b2b_overflow", 32'(OVERFLOW), 32'd0);

        // Overflow: three results while the transmitter is held busy
        clear_log();
        hold = 1;
        step(1'b1, 16'h1234, 1'b1);
        step(1'b1, 16'h5678, 1'b1);
        step(1'b1, 16'h9ABC, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("ovf_set", 32'(OVERFLOW), 32'd1);
        chk("ovf_no_send_while_busy", 32'(log_b.size()), 32'd0);
        hold = 0;
        wait_idle(100);
        chk("ovf_count", 32'(log_b.size()), 32'd4);
        chk("ovf_b0", 32'(log_b[0]), 32'h34);
        chk("ovf_b1", 32'(log_b[1]), 32'h12);
        chk("ovf_b2", 32'(log_b[2]), 32'h78);
        chk("ovf_b3", 32'(log_b[3]), 32'h56);
        chk("ovf_sticky", 32'(OVERFLOW), 32'd1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("ovf_cleared", 32'(OVERFLOW), 32'd0);

        // Push on pop: new result arrives in the cycle the full FIFO pops
        clear_log();
        hold = 1;
        step(1'b1, 16'h1111, 1'b1);
        step(1'b1, 16'h2222, 1'b1);
        step(1'b0, '0, 1'b1);
        hold = 0;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk);
            #1;
            uart_update();
            rst = 1'b1;
            ALU_OUT = 16'hBEEF;
            OUT_VALID = (m_active && m_byte == 1 && m_step == S_FALL && !TX_BUSY && mq.size() == D);
            if (OUT_VALID) hit = 1;
        end
        chk("pp_reached_exit", 32'(hit), 32'd1);
        wait_idle(100);
        chk("pp_overflow", 32'(OVERFLOW), 32'd0);
        chk("pp_count", 32'(log_b.size()), 32'd6);
        chk("pp_lo", 32'(log_b[4]), 32'hEF);
        chk("pp_hi", 32'(log_b[5]), 32'hBE);

        // Reset during ACK_LO, with OUT_VALID asserted in the reset cycle
        clear_log();
        step(1'b1, 16'hC33C, 1'b1);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step(1'b0, '0, 1'b1);
            if (TX_D_VLD === 1'b1) hit = 1;
        end
        chk("rst_mid_strobe_seen", 32'(hit), 32'd1);
        step(1'b1, 16'hDEAD, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("rst_mid_vld", 32'(TX_D_VLD), 32'd0);
        chk("rst_mid_busy", 32'(BUSY), 32'd0);
        repeat (30) step(1'b0, '0, 1'b1);
        chk("rst_mid_count", 32'(log_b.size()), 32'd1);
        chk("rst_mid_lo", 32'(log_b[0]), 32'h3C);

        // Transmitter already busy when a result arrives
        clear_log();
        hold = 1;
        step(1'b1, 16'h7E81, 1'b1);
        repeat (10) step(1'b0, '0, 1'b1);
        chk("busy_wait_none", 32'(log_b.size()), 32'd0);
        hold = 0;
        step(1'b0, '0, 1'b1);
        pc = cyc;
        wait_idle(100);
        chk("busy_wait_latency", 32'(log_c[0] - pc), 32'd1);
        chk("busy_wait_lo", 32'(log_b[0]), 32'h81);
        chk("busy_wait_hi", 32'(log_b[1]), 32'h7E);

        // Randomized traffic
        rand_frames = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(49, 0) == 0) hold = !hold;
            step($urandom_range(2, 0) == 0, 16'($urandom), $urandom_range(499, 0) != 0);
        end
        hold = 0;
        wait_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
